hidden_layer_mac: RTL and testbench

// - Reader side of the serial weight ring. Issues Get pulses and consumes the byte streamed on w_in.
// - Multiplies each weight by the matching input sample and accumulates N_IN products per hidden neuron.
// - Emits one saturated int8 activation per neuron, N_HID neurons per pass.
// - Sits between the weight ring and the output layer; the update path is untouched.

---
 rtl/hidden_layer_mac_pkg.sv | 38 +++
 rtl/hidden_layer_mac_if.sv | 36 +++
 rtl/hidden_layer_mac_act_sat.sv | 35 +++
 rtl/hidden_layer_mac.sv | 182 ++++++++++++++++++
 tb/tb_hidden_layer_mac.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hidden_layer_mac_pkg.sv
// ============================================================================
// Module : ann_pkg
// Brief  : Shared types, state encoding and int8 saturation for the hidden
//          layer multiply-accumulate datapath.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ann_pkg;

  localparam int W_BITS = 8;
  localparam int c_X_AW = 10;
  localparam int c_H_IW = 4;

  typedef logic signed [W_BITS-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } hstate_e;

  function automatic weight_t sat8(input logic signed [31:0] v);
    weight_t r;
    if (v > 32'sd127) begin
      r = weight_t'(8'h7F);
    end else if (v < -32'sd128) begin
      r = weight_t'(8'h80);
    end else begin
      r = v[W_BITS-1:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hidden_layer_mac_if.sv
// ============================================================================
// Module : hidden_layer_mac_if
// Brief  : Ring-reader, input-sample and activation signals of the hidden
//          layer MAC; master is the MAC, slave is its environment.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hidden_layer_mac_if;
  import ann_pkg::*;

  logic              start;
  weight_t           w_in;
  weight_t           x_data;
  logic              compute_h;
  logic              get;
  logic [c_X_AW-1:0] x_addr;
  weight_t           h_out;
  logic [c_H_IW-1:0] h_idx;
  logic              h_valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, w_in, x_data,
    output compute_h, get, x_addr, h_out, h_idx, h_valid, busy, done
  );

  modport slave (
    output start, w_in, x_data,
    input  compute_h, get, x_addr, h_out, h_idx, h_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/hidden_layer_mac_act_sat.sv
// ============================================================================
// Module : act_sat
// Brief  : Combinational accumulator-to-activation conversion: arithmetic
//          shift, int8 saturation, optional ReLU (macro HIDDEN_RELU_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_sat
  import ann_pkg::*;
#(
  parameter int ACC_W = 26,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  output weight_t                 h
);

  logic signed [ACC_W-1:0] w_shr;
  logic signed [31:0]      w_wide;
  weight_t                 w_sat;

  assign w_shr  = acc >>> SHIFT;
  assign w_wide = {{(32-ACC_W){w_shr[ACC_W-1]}}, w_shr};
  assign w_sat  = sat8(w_wide);

`ifdef HIDDEN_RELU_EN
  assign h = w_sat[W_BITS-1] ? '0 : w_sat;
`else
  assign h = w_sat;
`endif

endmodule

`default_nettype wire

// File: rtl/hidden_layer_mac.sv
// ============================================================================
// Module : hidden_layer_mac
// Brief  : Serial weight-ring reader and per-neuron MAC producing one int8
//          activation per hidden neuron; ReLU enabled by HIDDEN_RELU_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hidden_layer_mac
  import ann_pkg::*;
#(
  parameter int N_IN  = 800,
  parameter int N_HID = 10,
  parameter int DEPTH = 8001,
  parameter int SHIFT = 7,
  parameter int ACC_W = 16 + $clog2(N_IN)
) (
  input  logic               Clk,
  input  logic               RST,
  hidden_layer_mac_if.master bus
);

  localparam int c_PAD_N = DEPTH - N_IN * N_HID;
  localparam int c_PW    = (c_PAD_N > 1) ? $clog2(c_PAD_N) : 1;
  localparam logic [c_X_AW-1:0] c_IN_LAST  = c_X_AW'(N_IN - 1);
  localparam logic [c_H_IW-1:0] c_HID_LAST = c_H_IW'(N_HID - 1);
  localparam logic [c_PW-1:0]   c_PAD_LAST = c_PW'((c_PAD_N > 0) ? c_PAD_N - 1 : 0);

  hstate_e           r_state;
  logic [c_X_AW-1:0] r_in_cnt;
  logic [c_H_IW-1:0] r_nrn_cnt;
  logic [c_PW-1:0]   r_pad_cnt;
  logic              r_drain;
  logic              r_get;
  logic              r_compute_h;
  logic              r_busy;
  logic              r_done;

  logic              r_s1_vld;
  logic              r_s1_first;
  logic              r_s1_last;
  logic [c_H_IW-1:0] r_s1_idx;
  weight_t           r_w_q;

  logic signed [ACC_W-1:0] r_acc;
  weight_t                 r_h_out;
  logic [c_H_IW-1:0]       r_h_idx;
  logic                    r_h_valid;

  logic signed [15:0]      w_w16;
  logic signed [15:0]      w_x16;
  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  weight_t                 w_act;

  // Sequencer: outputs are registered alongside the state so they line up with it.
  always_ff @(posedge Clk) begin
    if (RST) begin
      r_state     <= IDLE;
      r_in_cnt    <= '0;
      r_nrn_cnt   <= '0;
      r_pad_cnt   <= '0;
      r_drain     <= 1'b0;
      r_get       <= 1'b0;
      r_compute_h <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= RUN;
            r_get       <= 1'b1;
            r_compute_h <= 1'b1;
            r_busy      <= 1'b1;
            r_in_cnt    <= '0;
            r_nrn_cnt   <= '0;
          end
        end
        RUN: begin
          if (r_in_cnt == c_IN_LAST) begin
            r_in_cnt <= '0;
            if (r_nrn_cnt == c_HID_LAST) begin
              r_nrn_cnt <= '0;
              if (c_PAD_N > 0) begin
                r_state   <= PAD;
                r_pad_cnt <= '0;
              end else begin
                r_state     <= DRAIN;
                r_get       <= 1'b0;
                r_compute_h <= 1'b0;
                r_drain     <= 1'b0;
              end
            end else begin
              r_nrn_cnt <= r_nrn_cnt + c_H_IW'(1);
            end
          end else begin
            r_in_cnt <= r_in_cnt + c_X_AW'(1);
          end
        end
        PAD: begin
          if (r_pad_cnt == c_PAD_LAST) begin
            r_state     <= DRAIN;
            r_get       <= 1'b0;
            r_compute_h <= 1'b0;
            r_drain     <= 1'b0;
          end else begin
            r_pad_cnt <= r_pad_cnt + c_PW'(1);
          end
        end
        DRAIN: begin
          if (!r_drain) begin
            r_drain <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_w16      = {{8{r_w_q[W_BITS-1]}}, r_w_q};
  assign w_x16      = {{8{bus.x_data[W_BITS-1]}}, bus.x_data};
  assign w_prod     = w_w16 * w_x16;
  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
  assign w_acc_next = (r_s1_first ? '0 : r_acc) + w_prod_ext;

  act_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_act_sat (
    .acc (w_acc_next),
    .h   (w_act)
  );

  // Stage 1 captures the weight with its tags; stage 2 meets the late x_data.
  always_ff @(posedge Clk) begin
    if (RST) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_idx   <= '0;
      r_w_q      <= '0;
      r_acc      <= '0;
      r_h_out    <= '0;
      r_h_idx    <= '0;
      r_h_valid  <= 1'b0;
    end else begin
      r_s1_vld   <= (r_state == RUN);
      r_s1_first <= (r_in_cnt == '0);
      r_s1_last  <= (r_in_cnt == c_IN_LAST);
      r_s1_idx   <= r_nrn_cnt;
      r_w_q      <= bus.w_in;
      r_h_valid  <= 1'b0;
      if (r_s1_vld) begin
        r_acc <= w_acc_next;
        if (r_s1_last) begin
          r_h_out   <= w_act;
          r_h_idx   <= r_s1_idx;
          r_h_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.compute_h = r_compute_h;
  assign bus.get       = r_get;
  assign bus.x_addr    = r_in_cnt;
  assign bus.h_out     = r_h_out;
  assign bus.h_idx     = r_h_idx;
  assign bus.h_valid   = r_h_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hidden_layer_mac.sv
// ============================================================================
// Module : tb_hidden_layer_mac
// Brief  : Scoreboard bench for two hidden_layer_mac instances (SHIFT 0 and 7)
//          fed by a modelled weight ring.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hidden_layer_mac;
  import ann_pkg::*;

  localparam int N_IN     = 800;
  localparam int N_HID    = 10;
  localparam int DEPTH    = 8001;
  localparam int c_BUDGET = 9000;
`ifdef HIDDEN_RELU_EN
  localparam int c_NEG_SAT = 0;
`else
  localparam int c_NEG_SAT = -128;
`endif

  typedef struct packed {
    logic [3:0]        idx;
    logic signed [7:0] val;
  } exp_t;

  logic Clk       = 1'b0;
  logic RST       = 1'b1;
  logic start     = 1'b0;
  logic end_req   = 1'b0;
  logic rst_chk   = 1'b0;
  logic abort_win = 1'b0;
  int   checks    = 0;
  int   failures  = 0;

  weight_t ring  [DEPTH];
  weight_t x_mem [N_IN];
  int      ptr0 = 0;
  int      ptr7 = 0;
  exp_t    q0[$];
  exp_t    q7[$];
  int      pq0[$];
  int      pq7[$];
  int      pass_gets [2];
  int      pass_hv   [2];

  always #5 Clk = ~Clk;

  hidden_layer_mac_if bus0 ();
  hidden_layer_mac_if bus7 ();

  assign bus0.start = start;
  assign bus7.start = start;
  assign bus0.w_in  = ring[ptr0];
  assign bus7.w_in  = ring[ptr7];

  hidden_layer_mac #(.N_IN(N_IN), .N_HID(N_HID), .DEPTH(DEPTH), .SHIFT(0), .ACC_W(26))
    u_dut0 (.Clk(Clk), .RST(RST), .bus(bus0));
  hidden_layer_mac #(.N_IN(N_IN), .N_HID(N_HID), .DEPTH(DEPTH), .SHIFT(7), .ACC_W(26))
    u_dut7 (.Clk(Clk), .RST(RST), .bus(bus7));

  // Ring head model and input-sample memory with one cycle of read latency.
  always @(posedge Clk) begin
    if (RST) begin
      ptr0 <= 0;
      ptr7 <= 0;
    end else begin
      if (bus0.get) ptr0 <= (ptr0 == DEPTH - 1) ? 0 : ptr0 + 1;
      if (bus7.get) ptr7 <= (ptr7 == DEPTH - 1) ? 0 : ptr7 + 1;
    end
    bus0.x_data <= x_mem[bus0.x_addr];
    bus7.x_data <= x_mem[bus7.x_addr];
  end

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm, input int val);
    checks++;
    failures++;
    $display("FAIL %s: got strobe (value %0d), expected none", nm, val);
  endfunction

  task automatic mon_one(input int d, input logic g, input logic hv, input logic dn,
                         input logic [3:0] hi, input weight_t ho);
    exp_t e;
    int   eg;
    if (g) pass_gets[d]++;
    if (hv) begin
      pass_hv[d]++;
      if (abort_win) unexpected($sformatf("h_valid_after_rst%0d", d), int'(ho));
      else if ((d == 0 && q0.size() == 0) || (d == 1 && q7.size() == 0))
        unexpected($sformatf("h_valid_extra%0d", d), int'(ho));
      else begin
        if (d == 0) e = q0.pop_front();
        else        e = q7.pop_front();
        chk($sformatf("h_idx%0d", d), int'(hi), int'(e.idx));
        chk($sformatf("h_out%0d_n%0d", d, e.idx), int'(ho), int'(e.val));
      end
    end
    if (dn) begin
      if (abort_win) unexpected($sformatf("done_after_rst%0d", d), 1);
      else if ((d == 0 && pq0.size() == 0) || (d == 1 && pq7.size() == 0))
        unexpected($sformatf("done_extra%0d", d), 1);
      else begin
        if (d == 0) eg = pq0.pop_front();
        else        eg = pq7.pop_front();
        chk($sformatf("gets_per_pass%0d", d), pass_gets[d], eg);
        chk($sformatf("h_valid_per_pass%0d", d), pass_hv[d], N_HID);
      end
      pass_gets[d] = 0;
      pass_hv[d]   = 0;
    end
  endtask

  task automatic rst_one(input int d, input logic cg, input logic g, input logic b,
                         input logic dn, input logic hv, input logic [9:0] xa,
                         input logic [3:0] hi, input weight_t ho);
    chk($sformatf("rst_compute_h%0d", d), int'(cg), 0);
    chk($sformatf("rst_get%0d", d), int'(g), 0);
    chk($sformatf("rst_busy%0d", d), int'(b), 0);
    chk($sformatf("rst_done%0d", d), int'(dn), 0);
    chk($sformatf("rst_h_valid%0d", d), int'(hv), 0);
    chk($sformatf("rst_x_addr%0d", d), int'(xa), 0);
    chk($sformatf("rst_h_idx%0d", d), int'(hi), 0);
    chk($sformatf("rst_h_out%0d", d), int'(ho), 0);
  endtask

  always @(negedge Clk) begin
    if (RST) begin
      pass_gets[0] = 0; pass_gets[1] = 0;
      pass_hv[0]   = 0; pass_hv[1]   = 0;
    end else begin
      mon_one(0, bus0.get, bus0.h_valid, bus0.done, bus0.h_idx, bus0.h_out);
      mon_one(1, bus7.get, bus7.h_valid, bus7.done, bus7.h_idx, bus7.h_out);
      if (rst_chk) begin
        rst_one(0, bus0.compute_h, bus0.get, bus0.busy, bus0.done, bus0.h_valid,
                bus0.x_addr, bus0.h_idx, bus0.h_out);
        rst_one(1, bus7.compute_h, bus7.get, bus7.busy, bus7.done, bus7.h_valid,
                bus7.x_addr, bus7.h_idx, bus7.h_out);
      end
      if (end_req) begin
        chk("pending_h0", q0.size(), 0);
        chk("pending_h7", q7.size(), 0);
        chk("pending_done0", pq0.size(), 0);
        chk("pending_done7", pq7.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  function automatic int model_h(input int n, input int sh);
    int sum;
    sum = 0;
    for (int i = 0; i < N_IN; i++) sum += int'(ring[n*N_IN+i]) * int'(x_mem[i]);
    sum = sum >>> sh;
    if (sum > 127)  sum = 127;
    if (sum < -128) sum = -128;
`ifdef HIDDEN_RELU_EN
    if (sum < 0) sum = 0;
`endif
    return sum;
  endfunction

  task automatic load(input int pat);
    for (int k = 0; k < DEPTH; k++) begin
      case (pat)
        0:       ring[k] = weight_t'(1);
        1:       ring[k] = (k % 2 == 0) ? weight_t'(1) : weight_t'(-1);
        2:       ring[k] = weight_t'(-128);
        default: ring[k] = weight_t'(((k * 7) % 11) - 5);
      endcase
    end
    ring[DEPTH-1] = weight_t'(77);
    for (int i = 0; i < N_IN; i++) begin
      case (pat)
        0:       x_mem[i] = weight_t'(1);
        1:       x_mem[i] = weight_t'(2);
        2:       x_mem[i] = weight_t'(127);
        default: x_mem[i] = weight_t'(((i * 3) % 13) - 6);
      endcase
    end
  endtask

  task automatic push_exp(input logic use_model, input int v0, input int v7);
    exp_t e;
    for (int n = 0; n < N_HID; n++) begin
      e.idx = 4'(n);
      e.val = 8'(use_model ? model_h(n, 0) : v0);
      q0.push_back(e);
      e.val = 8'(use_model ? model_h(n, 7) : v7);
      q7.push_back(e);
    end
  endtask

  task automatic do_pass(input int pulse_at);
    int cyc;
    pq0.push_back(DEPTH);
    pq7.push_back(DEPTH);
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(posedge Clk);
      #1 start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;
    end
    cyc = 0;
    while ((bus0.busy || bus7.busy) && cyc < c_BUDGET) begin
      @(posedge Clk); #1;
      cyc++;
    end
    if (cyc >= c_BUDGET) begin
      $display("FAIL pass_timeout: busy still high after %0d cycles, expected idle", cyc);
      $fatal(1, "pass did not complete");
    end
    repeat (3) @(posedge Clk);
  endtask

  initial begin
    load(0);
    repeat (3) @(posedge Clk);
    #1 RST = 1'b0; rst_chk = 1'b1;
    @(posedge Clk); #1 rst_chk = 1'b0;

    // 800 ones: saturates at SHIFT 0, 800 >>> 7 = 6 at SHIFT 7.
    push_exp(1'b0, 127, 6);
    do_pass(0);

    load(1);
    push_exp(1'b0, 0, 0);
    do_pass(0);

    // -128*127*800 = -13004800; saturates either way. Extra start mid-RUN.
    load(2);
    push_exp(1'b0, c_NEG_SAT, c_NEG_SAT);
    do_pass(300);
    push_exp(1'b0, c_NEG_SAT, c_NEG_SAT);
    do_pass(0);

    // Abort part-way through the first neuron.
    load(3);
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    repeat (399) @(posedge Clk);
    #1 RST = 1'b1; abort_win = 1'b1;
    repeat (2) @(posedge Clk);
    #1 RST = 1'b0; rst_chk = 1'b1;
    @(posedge Clk); #1 rst_chk = 1'b0;
    repeat (20) @(posedge Clk);
    #1 abort_win = 1'b0;

    push_exp(1'b1, 0, 0);
    do_pass(0);

    @(posedge Clk); #1 end_req = 1'b1;
    repeat (4) @(posedge Clk);
    $display("FAIL end_of_test: summary not reached, expected finish");
    $fatal(1, "bench did not finish");
  end

endmodule

`default_nettype wire
